// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Stall/flush/bubble sequencing and EX operand forwarding selects
//             for the 5-stage RV32I pipeline, built on EX/MEM/WB shadow slots.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             id_reg_write,
   input  logic             id_load,
   input  logic             id_mem,
   input  logic             ex_redirect,
   input  logic             mem_ready,
   output logic             stall_if,
   output logic             stall_id,
   output logic             stall_ex,
   output logic             flush_id,
   output logic             flush_ex,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef struct packed {
      logic       v;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       rw;
      logic       load;
      logic       mem;
   } ex_slot_t;

   typedef struct packed {
      logic       v;
      logic [4:0] rd;
      logic       rw;
      logic       mem;
   } mem_slot_t;

   typedef struct packed {
      logic       v;
      logic [4:0] rd;
      logic       rw;
   } wb_slot_t;

   localparam logic [1:0] c_FWD_RF  = 2'b00;
   localparam logic [1:0] c_FWD_MEM = 2'b01;
   localparam logic [1:0] c_FWD_WB  = 2'b10;

   ex_slot_t         ex_q,  ex_d;
   mem_slot_t        mem_q, mem_d;
   wb_slot_t         wb_q,  wb_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic w_mem_stall;
   logic w_redirect;
   logic w_load_use;
   logic w_rs1_hit;
   logic w_rs2_hit;
   logic w_stall_front;
   logic [1:0] w_fwd_a;
   logic [1:0] w_fwd_b;

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input mem_slot_t m,
                                          input wb_slot_t  w);
      logic [1:0] sel;
      sel = c_FWD_RF;
      if (m.v && m.rw && (m.rd != 5'd0) && (m.rd == rs)) begin
         sel = c_FWD_MEM;
      end else if (w.v && w.rw && (w.rd != 5'd0) && (w.rd == rs)) begin
         sel = c_FWD_WB;
      end
      return sel;
   endfunction

   // Raw hazard terms, then collapsed into a strict priority chain.
   always_comb begin
      w_rs1_hit     = id_uses_rs1 && (id_rs1 == ex_q.rd);
      w_rs2_hit     = id_uses_rs2 && (id_rs2 == ex_q.rd);
      w_mem_stall   = mem_q.v && mem_q.mem && !mem_ready;
      w_redirect    = !w_mem_stall && ex_q.v && ex_redirect;
      w_load_use    = !w_mem_stall && !w_redirect && id_valid && ex_q.v &&
                      ex_q.load && (ex_q.rd != 5'd0) && (w_rs1_hit || w_rs2_hit);
      w_stall_front = w_mem_stall || w_load_use;
      w_fwd_a       = ex_q.v ? fwd_sel(ex_q.rs1, mem_q, wb_q) : c_FWD_RF;
      w_fwd_b       = ex_q.v ? fwd_sel(ex_q.rs2, mem_q, wb_q) : c_FWD_RF;
   end

   always_comb begin
      stall_if  = !rst && w_stall_front;
      stall_id  = !rst && w_stall_front;
      stall_ex  = !rst && w_mem_stall;
      flush_id  = !rst && w_redirect;
      flush_ex  = !rst && (w_redirect || w_load_use);
      fwd_a     = rst ? c_FWD_RF : w_fwd_a;
      fwd_b     = rst ? c_FWD_RF : w_fwd_b;
      stall_cnt = rst ? '0 : stall_cnt_q;
   end

   always_comb begin
      ex_d        = ex_q;
      mem_d       = mem_q;
      wb_d        = wb_q;
      stall_cnt_d = stall_cnt_q;

      if (w_stall_front && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end

      // A memory wait freezes EX and MEM; WB is drained so it retires once.
      if (w_mem_stall) begin
         wb_d.v = 1'b0;
      end else begin
         wb_d.v    = mem_q.v;
         wb_d.rd   = mem_q.rd;
         wb_d.rw   = mem_q.rw;
         mem_d.v   = ex_q.v;
         mem_d.rd  = ex_q.rd;
         mem_d.rw  = ex_q.rw;
         mem_d.mem = ex_q.mem;
         if (w_redirect || w_load_use) begin
            ex_d.v = 1'b0;
         end else begin
            ex_d.v    = id_valid;
            ex_d.rs1  = id_rs1;
            ex_d.rs2  = id_rs2;
            ex_d.rd   = id_rd;
            ex_d.rw   = id_reg_write;
            ex_d.load = id_load;
            ex_d.mem  = id_mem;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         stall_cnt_q <= '0;
      end else begin
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         wb_q        <= wb_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl
//  Purpose  : Scoreboard bench for hazard_ctrl driven by instruction programs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

   localparam int CNT_W = 4;

   typedef struct {
      logic       v;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       u1;
      logic       u2;
      logic       rw;
      logic       ld;
      logic       mm;
      logic       redir;
      int         wait_n;
   } ins_t;

   typedef struct packed {
      logic [4:0]       ctl;   // stall_if, stall_id, stall_ex, flush_id, flush_ex
      logic [1:0]       fa;
      logic [1:0]       fb;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             id_valid = 1'b0;
   logic [4:0]       id_rs1 = '0;
   logic [4:0]       id_rs2 = '0;
   logic [4:0]       id_rd = '0;
   logic             id_uses_rs1 = 1'b0;
   logic             id_uses_rs2 = 1'b0;
   logic             id_reg_write = 1'b0;
   logic             id_load = 1'b0;
   logic             id_mem = 1'b0;
   logic             ex_redirect = 1'b0;
   logic             mem_ready = 1'b1;
   logic             stall_if, stall_id, stall_ex, flush_id, flush_ex;
   logic [1:0]       fwd_a, fwd_b;
   logic [CNT_W-1:0] stall_cnt;

   int   n_checks = 0;
   int   n_errors = 0;
   ins_t prog[$];
   exp_t expq[$];
   ins_t m_ex, m_mem, m_wb;
   int   m_cnt;

   hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_reg_write(id_reg_write), .id_load(id_load), .id_mem(id_mem),
      .ex_redirect(ex_redirect), .mem_ready(mem_ready), .stall_if(stall_if),
      .stall_id(stall_id), .stall_ex(stall_ex), .flush_id(flush_id),
      .flush_ex(flush_ex), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic ins_t mk(input int rd, input int rs1, input int rs2,
                               input bit u1, input bit u2, input bit rw,
                               input bit ld, input bit mm, input bit redir,
                               input int wait_n);
      ins_t i;
      i.v = 1'b1; i.rd = 5'(rd); i.rs1 = 5'(rs1); i.rs2 = 5'(rs2);
      i.u1 = u1; i.u2 = u2; i.rw = rw; i.ld = ld; i.mm = mm;
      i.redir = redir; i.wait_n = wait_n;
      return i;
   endfunction

   function automatic ins_t alu(input int rd, input int rs1, input int rs2);
      return mk(rd, rs1, rs2, 1, 1, 1, 0, 0, 0, 0);
   endfunction

   function automatic ins_t lw(input int rd, input int rs1, input int wait_n, input bit redir);
      return mk(rd, rs1, 0, 1, 0, 1, 1, 1, redir, wait_n);
   endfunction

   function automatic ins_t bubble();
      ins_t i;
      i.v = 1'b0; i.rd = 5'($urandom); i.rs1 = 5'($urandom); i.rs2 = 5'($urandom);
      i.u1 = 1'($urandom); i.u2 = 1'($urandom); i.rw = 1'($urandom);
      i.ld = 1'($urandom); i.mm = 1'($urandom); i.redir = 1'b0; i.wait_n = 0;
      return i;
   endfunction

   function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
      if (!m_ex.v) return 2'b00;
      if (m_mem.v && m_mem.rw && m_mem.rd != 0 && m_mem.rd == rs) return 2'b01;
      if (m_wb.v && m_wb.rw && m_wb.rd != 0 && m_wb.rd == rs) return 2'b10;
      return 2'b00;
   endfunction

   function automatic exp_t model_out(input ins_t id, input logic exr, input logic mrdy);
      exp_t e;
      bit ms, rd, lu;
      ms = m_mem.v && m_mem.mm && !mrdy;
      rd = m_ex.v && exr;
      lu = id.v && m_ex.v && m_ex.ld && m_ex.rd != 0 &&
           ((id.u1 && id.rs1 == m_ex.rd) || (id.u2 && id.rs2 == m_ex.rd));
      if (ms)      e.ctl = 5'b11100;
      else if (rd) e.ctl = 5'b00011;
      else if (lu) e.ctl = 5'b11001;
      else         e.ctl = 5'b00000;
      e.fa  = exp_fwd(m_ex.rs1);
      e.fb  = exp_fwd(m_ex.rs2);
      e.cnt = CNT_W'(m_cnt);
      return e;
   endfunction

   task automatic model_step(input ins_t id, input exp_t e);
      if (e.ctl[4] && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      if (e.ctl == 5'b11100) begin
         m_mem.wait_n--;
         m_wb.v = 1'b0;
      end else begin
         m_wb  = m_mem;
         m_mem = m_ex;
         if (e.ctl == 5'b00000) m_ex = id;
         else                   m_ex.v = 1'b0;
         if (!e.ctl[3] && prog.size() > 0) void'(prog.pop_front());
      end
   endtask

   task automatic run_cycle();
      ins_t id;
      logic exr, mrdy;
      exp_t e;
      id   = (prog.size() > 0) ? prog[0] : bubble();
      exr  = m_ex.v ? m_ex.redir : 1'($urandom_range(0, 1));
      mrdy = (m_mem.v && m_mem.mm) ? (m_mem.wait_n <= 0) : 1'($urandom_range(0, 1));
      id_valid = id.v; id_rs1 = id.rs1; id_rs2 = id.rs2; id_rd = id.rd;
      id_uses_rs1 = id.u1; id_uses_rs2 = id.u2; id_reg_write = id.rw;
      id_load = id.ld; id_mem = id.mm; ex_redirect = exr; mem_ready = mrdy;
      expq.push_back(model_out(id, exr, mrdy));
      @(negedge clk);
      e = expq.pop_front();
      chk("ctl", {27'd0, stall_if, stall_id, stall_ex, flush_id, flush_ex}, {27'd0, e.ctl});
      chk("fwd_a", {30'd0, fwd_a}, {30'd0, e.fa});
      chk("fwd_b", {30'd0, fwd_b}, {30'd0, e.fb});
      chk("stall_cnt", {28'd0, stall_cnt}, {28'd0, e.cnt});
      model_step(id, e);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      id_valid = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd5; id_rd = 5'd5;
      id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1; id_reg_write = 1'b1;
      id_load = 1'b1; id_mem = 1'b1; ex_redirect = 1'b1; mem_ready = 1'b0;
      expq.push_back('0);
      @(negedge clk);
      chk("rst_outputs", {19'd0, stall_if, stall_id, stall_ex, flush_id, flush_ex,
                          fwd_a, fwd_b, stall_cnt}, {19'd0, expq.pop_front()});
      @(posedge clk); #1;
      rst = 1'b0;
      m_ex.v = 1'b0; m_mem.v = 1'b0; m_wb.v = 1'b0; m_cnt = 0;
      prog.delete();
   endtask

   task automatic run_n(input int n);
      for (int k = 0; k < n; k++) run_cycle();
   endtask

   task automatic run_prog();
      int budget = 400;
      while ((prog.size() > 0 || m_ex.v || m_mem.v || m_wb.v) && budget > 0) begin
         run_cycle();
         budget--;
      end
      chk("drain_budget", {31'd0, budget > 0}, 32'd1);
   endtask

   initial begin
      m_ex = bubble(); m_mem = bubble(); m_wb = bubble(); m_cnt = 0;
      @(posedge clk); #1;
      do_reset();

      // Reset mid-operation with a dependent chain in flight.
      prog.push_back(alu(5, 1, 2)); prog.push_back(alu(6, 5, 5));
      prog.push_back(alu(7, 5, 6)); prog.push_back(lw(8, 7, 2, 0));
      run_n(4);
      do_reset();
      prog.push_back(alu(5, 5, 5)); prog.push_back(alu(6, 5, 5));
      run_prog();

      // Forwarding priority: EX/MEM over MEM/WB, x0 never forwards.
      prog.push_back(alu(5, 1, 2)); prog.push_back(alu(5, 3, 4)); prog.push_back(alu(7, 5, 5));
      prog.push_back(alu(5, 1, 2)); prog.push_back(alu(9, 1, 1)); prog.push_back(alu(7, 5, 5));
      prog.push_back(alu(0, 1, 2)); prog.push_back(alu(7, 0, 0));
      prog.push_back(mk(5, 1, 2, 1, 1, 0, 0, 1, 0, 0)); prog.push_back(alu(7, 5, 5));
      run_prog();

      // Load-use: one stall, then forward from MEM/WB; non-hazards must not stall.
      prog.push_back(lw(3, 2, 0, 0)); prog.push_back(alu(4, 3, 1));
      prog.push_back(lw(0, 2, 0, 0)); prog.push_back(alu(4, 0, 0));
      prog.push_back(lw(3, 2, 0, 0)); prog.push_back(mk(4, 1, 3, 1, 0, 1, 0, 0, 0, 0));
      run_prog();

      // Redirect wins over load-use; the dependent ID instruction is discarded.
      prog.push_back(lw(3, 2, 0, 1)); prog.push_back(alu(4, 3, 1)); prog.push_back(alu(6, 4, 4));
      run_prog();

      // Memory wait of 3 cycles, and a redirect held behind a 2-cycle wait.
      prog.push_back(alu(10, 1, 1)); prog.push_back(lw(3, 10, 3, 0));
      prog.push_back(alu(9, 10, 1)); prog.push_back(alu(8, 3, 9));
      run_prog();
      prog.push_back(lw(3, 2, 2, 0)); prog.push_back(mk(0, 3, 1, 1, 1, 0, 0, 0, 1, 0));
      prog.push_back(alu(4, 1, 1)); prog.push_back(alu(5, 4, 4));
      run_prog();

      // Counter saturation on a long memory wait.
      prog.push_back(lw(3, 2, 20, 0)); prog.push_back(alu(4, 3, 3));
      run_prog();
      do_reset();

      // Random mix over a small register set to provoke overlapping hazards.
      for (int k = 0; k < 60; k++) begin
         ins_t i;
         i = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), 1'($urandom), 1'($urandom), 0, 0, 0, 0);
         case ($urandom_range(0, 5))
            0: begin i.ld = 1'b1; i.mm = 1'b1; i.rw = 1'b1; i.wait_n = $urandom_range(0, 2); end
            1: begin i.mm = 1'b1; i.wait_n = $urandom_range(0, 1); end
            2: i.redir = ($urandom_range(0, 2) == 0);
            3: i.v = 1'b0;
            default: ;
         endcase
         prog.push_back(i);
      end
      run_prog();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
